reqack_fifo: RTL and testbench

- Buffered four-phase request–acknowledge pipeline stage with DEPTH data entries.
- Sits directly downstream of the two-to-one arbiter: its input port consumes the arbiter's consumer-side req/ack/dat.
- Its output port drives the next four-phase consumer.
- Decouples arbiter throughput from slow consumers: producers are acknowledged as soon as data is stored, not after downstream completion.

---
 rtl/reqack_pkg.sv | 12 +
 rtl/reqack_sync.sv | 23 ++
 rtl/reqack_fifo.sv | 135 +++++++++++++
 tb/tb_reqack_fifo.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reqack_pkg.sv
// Shared types and constants for the buffered four-phase req/ack FIFO stage.
package reqack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_ACK_WAIT = 2'd2
    } reqack_out_state_e;

    localparam int REQACK_SYNC_STAGES = 2;

endpackage

// File: rtl/reqack_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset to 0.
module reqack_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reqack_fifo.sv
// Buffered four-phase req/ack stage: acks producers on store, replays entries to the consumer.
// Define REQACK_FIFO_SYNC_EN to put 2-flop synchronizers on in_req and out_ack.
module reqack_fifo
    import reqack_pkg::*;
#(
    parameter  int DWIDTH = 1,
    parameter  int DEPTH  = 4,
    localparam int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_req,
    output logic              in_ack,
    input  logic [DWIDTH-1:0] in_dat,
    output logic              out_req,
    input  logic              out_ack,
    output logic [DWIDTH-1:0] out_dat,
    output logic [AWIDTH:0]   level,
    output reqack_out_state_e state_dbg
);

    // Handshake semantics: each port is four-phase. A request rises with data
    // stable, the acknowledge rises once the data is taken, the request falls,
    // then the acknowledge falls; a new request may only follow that.

    localparam logic [AWIDTH:0] LEVEL_FULL = (AWIDTH+1)'(DEPTH);

    logic              in_req_i;
    logic              out_ack_i;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    reqack_out_state_e state;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

`ifdef REQACK_FIFO_SYNC_EN
    reqack_sync #(.STAGES(REQACK_SYNC_STAGES)) u_sync_in_req (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (in_req),
        .q     (in_req_i)
    );

    reqack_sync #(.STAGES(REQACK_SYNC_STAGES)) u_sync_out_ack (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (out_ack),
        .q     (out_ack_i)
    );
`else
    assign in_req_i  = in_req;
    assign out_ack_i = out_ack;
`endif

    assign full      = (level == LEVEL_FULL);
    assign empty     = (level == '0);
    assign push      = in_req_i && !in_ack && !full;
    assign pop       = (state == ST_IDLE) && !empty;
    assign state_dbg = state;

    // Storage is not reset: a cleared level makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            in_ack <= 1'b0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            in_ack <= 1'b1;
        end else if (!in_req_i && in_ack) begin
            in_ack <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            out_req <= 1'b0;
            out_dat <= '0;
            rd_ptr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        out_dat <= mem[rd_ptr];
                        rd_ptr  <= rd_ptr + 1'b1;
                        out_req <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (out_ack_i) begin
                        out_req <= 1'b0;
                        state   <= ST_ACK_WAIT;
                    end
                end
                ST_ACK_WAIT: begin
                    if (!out_ack_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    out_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // A simultaneous push and pop leaves the count alone while both pointers move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
    a_level_range:  assert property (@(posedge clk) disable iff (!rst_n) level <= LEVEL_FULL);

endmodule

// File: tb/tb_reqack_fifo.sv
// Bench for reqack_fifo: cycle tables for single transfers plus scoreboarded multi-transfer sequences.
module tb_reqack_fifo;
    import reqack_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef REQACK_FIFO_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    typedef struct {
        logic          req;
        logic          ack;
        logic          exp_in_ack;
        logic          exp_out_req;
        logic [AW:0]   exp_level;
        logic [DW-1:0] exp_dat;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_req;
    logic              in_ack;
    logic [DW-1:0]     in_dat;
    logic              out_req;
    logic              out_ack;
    logic [DW-1:0]     out_dat;
    logic [AW:0]       level;
    reqack_out_state_e state_dbg;

    logic              man_ack;
    logic              cons_ack;
    logic              cons_en;
    logic              cons_rand;
    logic              mon_en;
    logic              prev_out_req;
    logic [AW:0]       max_level;

    logic [DW-1:0]     exp_q[$];
    vec_t              tbl[$];
    int                tests = 0;
    int                fails = 0;

    assign out_ack = cons_en ? cons_ack : man_ack;

    reqack_fifo #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_req    (in_req),
        .in_ack    (in_ack),
        .in_dat    (in_dat),
        .out_req   (out_req),
        .out_ack   (out_ack),
        .out_dat   (out_dat),
        .level     (level),
        .state_dbg (state_dbg)
    );

    // clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic cond_met(input int which);
        case (which)
            0:       return in_ack;
            1:       return !in_ack;
            2:       return !out_req;
            3:       return exp_q.size() == 0 && level == '0 && !out_req && state_dbg == ST_IDLE;
            4:       return level == 3'd2 && out_req;
            5:       return level == 3'd1 && out_req;
            default: return 1'b1;
        endcase
    endfunction

    task automatic wait_cond(input int which, input string name);
        int n = 0;
        while (!cond_met(which) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({"timeout ", name}, 32'(cond_met(which)), 32'd1);
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        in_dat = d;
        in_req = 1'b1;
        wait_cond(0, "in_ack rise");
        exp_q.push_back(d);
        in_req = 1'b0;
        wait_cond(1, "in_ack fall");
    endtask

    task automatic drain();
        cons_en = 1'b1;
        wait_cond(3, "drain");
    endtask

    task automatic add_row(input logic r, input logic a, input logic ia, input logic orq,
                           input logic [AW:0] lv, input logic [DW-1:0] dt);
        vec_t v;
        v.req = r; v.ack = a; v.exp_in_ack = ia; v.exp_out_req = orq;
        v.exp_level = lv; v.exp_dat = dt;
        tbl.push_back(v);
    endtask

    // Single transfer, one row per clock edge; prev is out_dat before the pop.
    task automatic run_table(input logic [DW-1:0] d, input logic [DW-1:0] prev);
        tbl.delete();
        if (SYNC) begin
            add_row(1, 0, 0, 0, 0, prev);
            add_row(1, 0, 0, 0, 0, prev);
            add_row(1, 0, 1, 0, 1, prev);
            add_row(0, 0, 1, 1, 0, d);
            add_row(0, 1, 1, 1, 0, d);
            add_row(0, 1, 0, 1, 0, d);
            add_row(0, 1, 0, 0, 0, d);
            add_row(0, 0, 0, 0, 0, d);
            add_row(0, 0, 0, 0, 0, d);
            add_row(0, 0, 0, 0, 0, d);
        end else begin
            add_row(1, 0, 1, 0, 1, prev);
            add_row(0, 0, 0, 1, 0, d);
            add_row(0, 1, 0, 0, 0, d);
            add_row(0, 0, 0, 0, 0, d);
        end
        in_dat = d;
        for (int i = 0; i < tbl.size(); i++) begin
            in_req  = tbl[i].req;
            man_ack = tbl[i].ack;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl %0h edge%0d in_ack", d, i + 1), 32'(in_ack), 32'(tbl[i].exp_in_ack));
            check($sformatf("tbl %0h edge%0d out_req", d, i + 1), 32'(out_req), 32'(tbl[i].exp_out_req));
            check($sformatf("tbl %0h edge%0d level", d, i + 1), 32'(level), 32'(tbl[i].exp_level));
            check($sformatf("tbl %0h edge%0d out_dat", d, i + 1), 32'(out_dat), 32'(tbl[i].exp_dat));
        end
        check($sformatf("tbl %0h final state", d), 32'(state_dbg), 32'(ST_IDLE));
    endtask

    // Consumer: acks every presented word, optionally after a random delay.
    initial begin
        cons_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (cons_en && out_req && !cons_ack) begin
                if (cons_rand) repeat ($urandom_range(0, 3)) @(negedge clk);
                cons_ack = 1'b1;
                wait_cond(2, "consumer out_req fall");
                cons_ack = 1'b0;
            end
        end
    end

    // Scoreboard: every new word on the output is checked against the queue.
    initial begin
        prev_out_req = 1'b0;
        max_level    = '0;
        forever begin
            @(negedge clk);
            if (level > max_level) max_level = level;
            if (mon_en && out_req && !prev_out_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected output word", 32'(out_dat), 32'hFFFF_FFFF);
                end else begin
                    check("out_dat order", 32'(out_dat), 32'(exp_q.pop_front()));
                end
            end
            prev_out_req = out_req;
        end
    end

    initial begin
        logic [AW:0] lvl_min;
        logic [AW:0] lvl_max;
        int          n;

        rst_n     = 1'b0;
        in_req    = 1'b0;
        in_dat    = '0;
        man_ack   = 1'b0;
        cons_en   = 1'b0;
        cons_rand = 1'b0;
        mon_en    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ack", 32'(in_ack), 32'd0);
        check("reset out_req", 32'(out_req), 32'd0);
        check("reset out_dat", 32'(out_dat), 32'd0);
        check("reset level", 32'(level), 32'd0);
        check("reset state", 32'(state_dbg), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        run_table(8'h01, 8'h00);
        run_table(8'hA5, 8'h01);
        run_table(8'h3C, 8'hA5);

        // fill to full, then a sixth word must wait for a free slot
        mon_en = 1'b1;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        push_word(8'h44);
        push_word(8'h55);
        check("fill level", 32'(level), 32'd4);
        check("fill out_req", 32'(out_req), 32'd1);
        check("fill out_dat", 32'(out_dat), 32'h11);
        in_dat = 8'h66;
        in_req = 1'b1;
        repeat (6) @(negedge clk);
        check("full holds in_ack", 32'(in_ack), 32'd0);
        check("full level", 32'(level), 32'd4);
        cons_en = 1'b1;
        wait_cond(0, "0x66 accepted");
        exp_q.push_back(8'h66);
        in_req = 1'b0;
        wait_cond(1, "0x66 in_ack fall");
        drain();

        // pointer wrap with a randomly slow consumer
        max_level = '0;
        cons_rand = 1'b1;
        for (int i = 0; i < 10; i++) push_word(DW'(i));
        drain();
        check("wrap level bound", 32'(max_level <= 3'd4), 32'd1);
        cons_rand = 1'b0;

        // push lands on the same edge as the FSM pop while level is 1
        cons_en = 1'b0;
        push_word(8'h71);
        push_word(8'h72);
        wait_cond(5, "level1 with out_req");
        man_ack = 1'b1;
        wait_cond(2, "out_req fall before pop");
        man_ack = 1'b0;
        @(negedge clk);
        in_dat  = 8'h73;
        in_req  = 1'b1;
        lvl_min = level;
        lvl_max = level;
        n = 0;
        while (!in_ack && n < 50) begin
            @(negedge clk);
            if (level < lvl_min) lvl_min = level;
            if (level > lvl_max) lvl_max = level;
            n++;
        end
        check("simul in_ack", 32'(in_ack), 32'd1);
        check("simul level min", 32'(lvl_min), 32'd1);
        check("simul level max", 32'(lvl_max), 32'd1);
        check("simul out_req", 32'(out_req), 32'd1);
        check("simul state", 32'(state_dbg), 32'(ST_REQ));
        check("simul out_dat", 32'(out_dat), 32'h72);
        exp_q.push_back(8'h73);
        in_req = 1'b0;
        wait_cond(1, "simul in_ack fall");
        drain();

        // reset while a word is presented and two more are stored
        cons_en = 1'b0;
        push_word(8'h81);
        push_word(8'h82);
        push_word(8'h83);
        wait_cond(4, "level2 with out_req");
        check("pre-reset level", 32'(level), 32'd2);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("mid reset out_req", 32'(out_req), 32'd0);
        check("mid reset in_ack", 32'(in_ack), 32'd0);
        check("mid reset level", 32'(level), 32'd0);
        check("mid reset out_dat", 32'(out_dat), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_table(8'h5A, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
